// File: rtl/mux_nway_pkg.sv
// Shared constants for the N-way registered multiplexer: select-mode encodings and the way limit.
package mux_nway_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int unsigned WAYS_MAX = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requesting way at or after ptr, wrapping modulo WAYS.
module rr_arbiter #(
  parameter int unsigned  WAYS = 8,
  localparam int unsigned SelW = $clog2(WAYS)
) (
  input  logic [WAYS-1:0] req,
  input  logic [SelW-1:0] ptr,
  output logic [SelW-1:0] gnt_idx,
  output logic            gnt_vld
);

  logic [SelW-1:0] idx;

  // Scan from farthest to nearest offset so the nearest requester is the last write.
  always_comb begin
    gnt_vld = |req;
    gnt_idx = '0;
    idx     = '0;
    for (int k = int'(WAYS) - 1; k >= 0; k--) begin
      idx = SelW'((int'(ptr) + k) % int'(WAYS));
      if (req[idx]) begin
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/mux_nway_reg.sv
// N-way W-bit mux with fixed or round-robin select and a registered valid/ready output stage.
// Optional registered parity output enabled by defining MUX_NWAY_REG_PARITY_EN.
module mux_nway_reg
  import mux_nway_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned WAYS  = 8,
  parameter int unsigned SEL_W = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WAYS*WIDTH-1:0] in_data,
  input  logic [WAYS-1:0]       in_valid,
  output logic [WAYS-1:0]       in_ready,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef MUX_NWAY_REG_PARITY_EN
  ,
  output logic                  out_parity
`endif
);

  logic [WIDTH-1:0] way_data [WAYS];

  for (genvar i = 0; i < WAYS; i++) begin : g_way
    assign way_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;

  logic [SEL_W-1:0] rr_idx, gnt_idx;
  logic             rr_vld, fix_vld, gnt_vld;
  logic             load;

  rr_arbiter #(
    .WAYS(WAYS)
  ) u_rr_arbiter (
    .req    (in_valid),
    .ptr    (rr_ptr_q),
    .gnt_idx(rr_idx),
    .gnt_vld(rr_vld)
  );

  // Out-of-range selects (non-power-of-2 WAYS) never grant.
  always_comb begin
    fix_vld = 1'b0;
    if (int'(sel) < int'(WAYS)) begin
      fix_vld = in_valid[sel];
    end
  end

  assign gnt_idx = (mode == MODE_RR) ? rr_idx : sel;
  assign gnt_vld = (mode == MODE_RR) ? rr_vld : fix_vld;

  // No handshake is offered while reset is asserted.
  assign load     = rst_n && (!out_valid_q || out_ready);
  assign in_ready = (load && gnt_vld) ? (WAYS'(1) << gnt_idx) : '0;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    if (load) begin
      if (gnt_vld) begin
        out_valid_d = 1'b1;
        out_data_d  = way_data[gnt_idx];
        out_sel_d   = gnt_idx;
        if (mode == MODE_RR) begin
          rr_ptr_d = (gnt_idx == SEL_W'(WAYS - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

`ifdef MUX_NWAY_REG_PARITY_EN
  logic parity_q;

  // Parity of the next data word tracks both loads and holds of the data register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^out_data_d;
    end
  end

  assign out_parity = parity_q;
`endif

endmodule
